// File: rtl/fdiv2_sched_if.sv
// Handshake bundle between two requesters, the halving scheduler and one result consumer.
interface fdiv2_sched_if #(
   parameter int I_DATA = 16,
   parameter int CNT_W  = 4
);
   logic              req0_valid;
   logic              req0_ready;
   logic [I_DATA-1:0] req0_data;
   logic [CNT_W-1:0]  req0_shift;
   logic              req1_valid;
   logic              req1_ready;
   logic [I_DATA-1:0] req1_data;
   logic [CNT_W-1:0]  req1_shift;
   logic              out_valid;
   logic              out_ready;
   logic [I_DATA-1:0] out_data;
   logic              out_id;
   logic              busy;

   modport slave (
      input  req0_valid, req0_data, req0_shift,
      input  req1_valid, req1_data, req1_shift,
      input  out_ready,
      output req0_ready, req1_ready,
      output out_valid, out_data, out_id, busy
   );

   modport master (
      output req0_valid, req0_data, req0_shift,
      output req1_valid, req1_data, req1_shift,
      output out_ready,
      input  req0_ready, req1_ready,
      input  out_valid, out_data, out_id, busy
   );
endinterface

// File: rtl/fdiv2.sv
// One halving step of a {sign, exp, mnt} value: decrement the exponent, or shift the
// mantissa once the exponent is already zero. No Inf/NaN handling.
module fdiv2 #(
   parameter int I_EXP = 8,
   parameter int I_MNT = 7
) (
   input  logic [I_EXP+I_MNT:0] i_a,
   output logic [I_EXP+I_MNT:0] o_y
);
   logic [I_EXP-1:0] w_exp;

   assign w_exp = i_a[I_MNT +: I_EXP];

   // Exponent 1 decrements to 0 like any other, which leaves the mantissa untouched.
   always_comb begin
      o_y = i_a;
      if (w_exp == {I_EXP{1'b0}}) begin
         o_y[I_MNT-1:0] = {1'b0, i_a[I_MNT-1:1]};
      end else begin
         o_y[I_MNT +: I_EXP] = w_exp - I_EXP'(1);
      end
   end
endmodule

// File: rtl/fdiv2_sched.sv
// Two-requester round-robin scheduler that divides an operand by 2^k by stepping it
// k times through a single shared fdiv2 unit, then holds the result until consumed.
module fdiv2_sched #(
   parameter int I_EXP  = 8,
   parameter int I_MNT  = 7,
   parameter int I_DATA = I_EXP + I_MNT + 1,
   parameter int CNT_W  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   fdiv2_sched_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [I_DATA-1:0] r_data;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_id;
   logic              r_last;
   logic              r_out_valid;
   logic [I_DATA-1:0] r_out_data;
   logic              r_out_id;
   logic              r_busy;

   logic              w_gnt0;
   logic              w_gnt1;
   logic [I_DATA-1:0] w_sel_data;
   logic [CNT_W-1:0]  w_sel_shift;
   logic [I_DATA-1:0] w_step;

   fdiv2 #(.I_EXP(I_EXP), .I_MNT(I_MNT)) u_fdiv2 (
      .i_a (r_data),
      .o_y (w_step)
   );

   // Grant decision; r_last names the requester served most recently, so contention favours the other.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (rst_n && (r_state == ST_IDLE)) begin
         if (bus.req0_valid && bus.req1_valid) begin
            w_gnt0 = r_last;
            w_gnt1 = ~r_last;
         end else begin
            w_gnt0 = bus.req0_valid;
            w_gnt1 = bus.req1_valid;
         end
      end else begin
         w_gnt0 = 1'b0;
         w_gnt1 = 1'b0;
      end
   end

   // Operand mux for the granted requester.
   always_comb begin
      w_sel_data  = bus.req0_data;
      w_sel_shift = bus.req0_shift;
      if (w_gnt1) begin
         w_sel_data  = bus.req1_data;
         w_sel_shift = bus.req1_shift;
      end else begin
         w_sel_data  = bus.req0_data;
         w_sel_shift = bus.req0_shift;
      end
   end

   // Scheduler FSM: accept in IDLE, step in RUN, hold the result in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_data      <= {I_DATA{1'b0}};
         r_cnt       <= {CNT_W{1'b0}};
         r_id        <= 1'b0;
         r_last      <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= {I_DATA{1'b0}};
         r_out_id    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  r_data <= w_sel_data;
                  r_cnt  <= w_sel_shift;
                  r_id   <= w_gnt1;
                  r_busy <= 1'b1;
                  if (w_sel_shift == {CNT_W{1'b0}}) begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                     r_out_data  <= w_sel_data;
                     r_out_id    <= w_gnt1;
                  end else begin
                     r_state <= ST_RUN;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_data <= w_step;
               r_cnt  <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_step;
                  r_out_id    <= r_id;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_last      <= r_out_id;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_data   = r_out_data;
   assign bus.out_id     = r_out_id;
   assign bus.busy       = r_busy;
endmodule

// File: doc/fdiv2_sched.md
FDIV2_SCHED -- requirements
Module: fdiv2_sched

Interface
Parameters
REQ-001 The block SHALL have parameter I_EXP, default 8, meaning exponent width.
REQ-002 The block SHALL have parameter I_MNT, default 7, meaning mantissa width.
REQ-003 The block SHALL have parameter I_DATA, default I_EXP+I_MNT+1, meaning operand width ({sign, exp, mnt}).
REQ-004 The block SHALL have parameter CNT_W, default 4, meaning shift-count width.

Ports
REQ-005 The block SHALL have one clock, clk, and reset rst_n, which is asynchronous and active-low.
REQ-006 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- req0_valid  in  1  requester 0 has an operand
- req0_ready  out  1  requester 0 operand accepted this cycle
- req0_data  in  I_DATA  requester 0 operand
- req0_shift  in  CNT_W  requester 0 halving count k
- req1_valid, req1_ready, req1_data, req1_shift: as requester 0, for requester 1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  I_DATA  result = operand / 2^k
- out_id  out  1  requester index of the result
- busy  out  1  state != IDLE

Function
REQ-007 The block SHALL instantiate exactly one fdiv2 unit and use it for all halving steps.
REQ-008 Each halving step SHALL behave as follows:
- sign is unchanged;
- exp==0: mantissa shifts right by 1 and exp stays 0;
- exp==1: exp becomes 0 and the mantissa is unchanged;
- otherwise: exp decrements by 1 and the mantissa is unchanged;
- no Inf/NaN special-casing (exp all-ones decrements).
REQ-009 The FSM SHALL have states IDLE, RUN and DONE.
REQ-010 In IDLE, if any reqN_valid is high, the block SHALL grant exactly one requester.
- If only one is valid, that requester is granted.
- If both are valid, the requester not granted last is granted (round-robin).
REQ-011 reqN_ready SHALL be high only in IDLE for the granted requester, and is combinational from the valid inputs.
REQ-012 On the accept edge (reqN_valid && reqN_ready), the block SHALL register data, shift and id.
- If shift==0, next state is DONE.
- Otherwise, next state is RUN.
REQ-013 In RUN, each clock edge SHALL replace the data register with its fdiv2 result and decrement the count.
- When the count reaches 0, next state is DONE.
REQ-014 Latency: out_valid SHALL assert exactly k+1 cycles after the accept edge, where k = 0..2^CNT_W-1.
REQ-015 In DONE, out_valid SHALL be 1, and out_data and out_id SHALL stay stable until the out_valid && out_ready edge; the block then returns to IDLE and updates the last-grant pointer.
REQ-016 out_valid SHALL be 0 in IDLE and RUN.
REQ-017 No new request SHALL be accepted in RUN or DONE; both reqN_ready SHALL be 0 there.
REQ-018 A request accepted in the same cycle that a result retires SHALL NOT occur; the earliest new accept is the cycle after DONE exits (one-bubble turnaround).
REQ-019 Input changes on reqN_data and reqN_shift after acceptance SHALL NOT affect the operation in flight.
REQ-020 out_data SHALL hold the last result after retirement, until the next DONE.

Reset
REQ-021 While rst_n=0, the block SHALL hold:
- state = IDLE;
- out_valid, req0_ready, req1_ready, busy = 0;
- out_data = 0, out_id = 0;
- count = 0;
- last-grant pointer = 1, so req0 wins the first contention.
REQ-022 An assertion of rst_n during RUN or DONE SHALL abort the operation immediately, with no result emitted, and the in-flight operand SHALL be discarded.
REQ-023 After rst_n deasserts, the block SHALL accept a request on the first clock edge at which valid is high.

Verification
REQ-024 Single step: req0 with 0x4080, k=1 -> out_data=0x4000, out_id=0, out_valid 2 cycles after accept.
REQ-025 Subnormal boundary: req1 with 0x0081, k=3 -> step results 0x0001, 0x0000, 0x0000; out_data=0x0000, out_id=1, latency 4.
REQ-026 Pass-through: req0 with 0xC000, k=0 -> out_data=0xC000 (sign kept), out_valid 1 cycle after accept.
REQ-027 Contention: both valid from reset, req0=0x7F80 k=1, req1=0x3F80 k=2 -> req0 first with 0x7F00 id0, then req1 with 0x3E80 id1; a third simultaneous contention grants req0 again.
REQ-028 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_data and out_id stable, out_valid=1, both reqN_ready=0, busy=1.
REQ-029 Reset mid-RUN: req0 with k=8, rst_n pulsed low at the 3rd RUN cycle -> immediately state IDLE, out_valid=0, busy=0, no result ever emitted for that request.
